// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   state_t    : FSM encoding (IDLE / GRANT)
//   NUM_REQ    : number of requesters
//   IDX_W      : width of a requester index
//   HOLD_W     : width of the grant hold counter
//   IDLE_GNT_N : active-low grant vector with no grant
package rr_arbiter8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    localparam logic [NUM_REQ-1:0] IDLE_GNT_N = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_arbiter8_pkg

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : index where the search starts (wraps 7 -> 0)
//   any : at least one request is set
//   idx : first set request at or above ptr, wrapping
module rr_pick
    import rr_arbiter8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with forced release after MAX_HOLD grant cycles.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : enable; low blocks new grants and releases an active one
//   req       : active-high requests
//   done      : release pulse from the current grantee
//   gnt_n     : active-low one-hot grant, all ones when idle
//   gnt_idx   : binary index of the grantee, 0 when idle
//   gnt_valid : high while a grant is active
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt_n,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0]  gnt_n_q, gnt_n_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic                gnt_valid_q, gnt_valid_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;
    logic                release_c;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Any one of these ends the current grant at the next edge.
    assign release_c = done
                    || !req[gnt_idx_q]
                    || !en
                    || (hold_q == HOLD_W'(MAX_HOLD - 1));

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_n_q     <= IDLE_GNT_N;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_n_q     <= gnt_n_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_n_d     = gnt_n_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;

        case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    state_d     = GRANT;
                    hold_d      = '0;
                    gnt_idx_d   = pick_idx;
                    gnt_n_d     = ~(NUM_REQ'(1) << pick_idx);
                    gnt_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    // Always drop to IDLE so grants never switch back-to-back.
                    state_d     = IDLE;
                    ptr_d       = gnt_idx_q + IDX_W'(1);
                    gnt_n_d     = IDLE_GNT_N;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_n     = gnt_n_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (instantiated with MAX_HOLD=4).
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks   = 0;
    int failures = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt_n     (gnt_n),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] exp_n,
                       input logic [2:0] exp_idx, input logic exp_v);
        checks++;
        assert ({gnt_n, gnt_idx, gnt_valid} === {exp_n, exp_idx, exp_v})
        else begin
            failures++;
            $error("FAIL %s: got gnt_n=%h gnt_idx=%0d gnt_valid=%b, want gnt_n=%h gnt_idx=%0d gnt_valid=%b",
                   tag, gnt_n, gnt_idx, gnt_valid, exp_n, exp_idx, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 8'hFF, 3'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] one;
        logic [2:0] k3;
        one   = 8'h01;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset_state");
        rst_n = 1'b1;

        // Single requester 2, done during its third grant cycle
        en  = 1'b1;
        req = 8'h04;
        @(negedge clk); chk("single_c1", 8'hFB, 3'd2, 1'b1);
        @(negedge clk); chk("single_c2", 8'hFB, 3'd2, 1'b1);
        @(negedge clk); chk("single_c3", 8'hFB, 3'd2, 1'b1);
        done = 1'b1;
        @(negedge clk); chk_idle("single_release");
        done = 1'b0;
        // ptr is now 3: with 2 and 3 requesting, 3 wins
        req = 8'h0C;
        @(negedge clk); chk("ptr_after_single", 8'hF7, 3'd3, 1'b1);

        // Asynchronous reset in the middle of the grant to requester 3
        #2 rst_n = 1'b0;
        #1 chk_idle("async_reset_mid_grant");
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin over all requesters, done asserted throughout
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            k3 = 3'(k % 8);
            @(negedge clk); chk($sformatf("rr_grant_%0d", k), ~(one << k3), k3, 1'b1);
            @(negedge clk); chk_idle($sformatf("rr_idle_%0d", k));
        end
        req  = 8'h00;
        done = 1'b0;

        // Reset again so the timeout sequence searches from 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout: requesters 0 and 7 hold requests, no done
        req = 8'h81;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk($sformatf("tmo_idx0_c%0d", c), 8'hFE, 3'd0, 1'b1);
        end
        @(negedge clk); chk_idle("tmo_idle_a");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk($sformatf("tmo_idx7_c%0d", c), 8'h7F, 3'd7, 1'b1);
        end
        @(negedge clk); chk_idle("tmo_idle_b");
        @(negedge clk); chk("tmo_idx0_again", 8'hFE, 3'd0, 1'b1);
        req = 8'h00;
        @(negedge clk); chk_idle("tmo_req_drop");

        // Enable: blocked while en=0, granted one cycle after en rises
        en  = 1'b0;
        req = 8'h10;
        @(negedge clk); chk_idle("en_off_a");
        @(negedge clk); chk_idle("en_off_b");
        en = 1'b1;
        @(negedge clk); chk("en_on_grant", 8'hEF, 3'd4, 1'b1);
        en = 1'b0;
        @(negedge clk); chk_idle("en_off_release");
        @(negedge clk); chk_idle("en_off_stays_idle");

        // Request drop: grant 5, drop req[5], then 0 is served by wrap from 6
        en  = 1'b1;
        req = 8'h20;
        @(negedge clk); chk("drop_grant5", 8'hDF, 3'd5, 1'b1);
        req = 8'h01;
        @(negedge clk); chk_idle("drop_release");
        req = 8'h21;
        @(negedge clk); chk("drop_wrap_idx0", 8'hFE, 3'd0, 1'b1);

        // done together with a new request: release wins
        done = 1'b1;
        req  = 8'h23;
        @(negedge clk); chk_idle("done_priority");
        done = 1'b0;
        @(negedge clk); chk("after_done_idx1", 8'hFD, 3'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_arbiter8
